// File: rtl/vec_pack_pkg.sv
// Shared constants and types for the vector packer family.
package vec_pack_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int unsigned DEF_BUS_WIDTH    = 128;
  localparam int unsigned DEF_VECTOR_WIDTH = 920;

  function automatic int unsigned calc_sub_vec_no(input int unsigned bus_width,
                                                  input int unsigned vector_width);
    return (vector_width + bus_width - 1) / bus_width;
  endfunction

  // Valid bits carried by the final sub-vector of a vector.
  function automatic int unsigned calc_vb(input int unsigned bus_width,
                                          input int unsigned vector_width,
                                          input int unsigned sub_vec_no);
    return vector_width - (sub_vec_no - 1) * bus_width;
  endfunction

  // Zero padding below the valid bits of the final sub-vector.
  function automatic int unsigned calc_delta(input int unsigned bus_width,
                                             input int unsigned vector_width,
                                             input int unsigned sub_vec_no);
    return bus_width - calc_vb(bus_width, vector_width, sub_vec_no);
  endfunction

  localparam int unsigned DEF_SUB_VEC_NO = calc_sub_vec_no(DEF_BUS_WIDTH, DEF_VECTOR_WIDTH);
  localparam int unsigned DEF_VB         = calc_vb(DEF_BUS_WIDTH, DEF_VECTOR_WIDTH, DEF_SUB_VEC_NO);
  localparam int unsigned DEF_DELTA      = calc_delta(DEF_BUS_WIDTH, DEF_VECTOR_WIDTH, DEF_SUB_VEC_NO);

endpackage

// File: rtl/vec_pack_outreg.sv
// One-entry output register with valid/ready handshake.
module vec_pack_outreg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] vector,
  output logic             is_last,
  output logic             free
);

  assign free = !valid || ready;

  // Load a new word, or drop valid once downstream has taken the current one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid   <= 1'b0;
      vector  <= '0;
      is_last <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      vector  <= data;
      is_last <= last;
    end else if (ready) begin
      valid   <= 1'b0;
      is_last <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_pack.sv
// Packs fixed-width vectors, delivered as bus-width sub-vectors with a
// zero-padded tail, into a dense MSB-first word stream.
module vec_pack
  import vec_pack_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int unsigned VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int unsigned VEC_ID_WIDTH = 8,
  parameter int unsigned SUB_VEC_NO   = calc_sub_vec_no(BUS_WIDTH, VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [BUS_WIDTH-1:0]    dn_Vector,
  output logic                    dn_Valid,
  output logic                    dn_Last,
  input  logic                    dn_Ready,
  output logic [VEC_ID_WIDTH-1:0] dn_VecCnt,
  output logic                    dn_Err
);

  localparam int unsigned VB    = calc_vb(BUS_WIDTH, VECTOR_WIDTH, SUB_VEC_NO);
  localparam int unsigned DELTA = calc_delta(BUS_WIDTH, VECTOR_WIDTH, SUB_VEC_NO);
  localparam int unsigned FW    = $clog2(2 * BUS_WIDTH) + 1;
  localparam int unsigned CW    = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;

  localparam logic [BUS_WIDTH-1:0] ONES    = '1;
  localparam logic [BUS_WIDTH-1:0] VB_MASK = ONES << DELTA;

  state_t                  state, state_nxt;
  logic [BUS_WIDTH-1:0]    acc;
  logic [FW-1:0]           fill;
  logic [CW-1:0]           sub;
  logic [VEC_ID_WIDTH-1:0] cnt;
  logic                    err;

  logic                    is_final;
  logic [FW-1:0]           n;
  logic [FW-1:0]           new_fill;
  logic                    full;
  logic                    has_residual;
  logic [BUS_WIDTH-1:0]    in_bits;
  logic [2*BUS_WIDTH-1:0]  cat;

  logic                    accept;
  logic                    free;
  logic                    ld;
  logic [BUS_WIDTH-1:0]    ld_data;
  logic                    ld_last;

  assign is_final     = (sub == CW'(SUB_VEC_NO - 1));
  assign n            = is_final ? FW'(VB) : FW'(BUS_WIDTH);
  assign new_fill     = fill + n;
  assign full         = (new_fill >= FW'(BUS_WIDTH));
  assign has_residual = (new_fill > FW'(BUS_WIDTH));
  assign in_bits      = is_final ? (up_Vector & VB_MASK) : up_Vector;
  // acc is zero below its fill bits, so OR-ing the shifted input appends it.
  assign cat          = {acc, {BUS_WIDTH{1'b0}}} | ({in_bits, {BUS_WIDTH{1'b0}}} >> fill);

  assign dn_VecCnt    = cnt;
  assign dn_Err       = err;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state: a terminating word that leaves a residual needs an extra flush word.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (accept && up_Last && has_residual) state_nxt = FLUSH;
      FLUSH:   if (free) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs: upstream ready and the output-register load request.
  always_comb begin
    up_Ready = 1'b0;
    accept   = 1'b0;
    ld       = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    unique case (state)
      RUN: begin
        up_Ready = rstn && free;
        accept   = up_Valid && up_Ready;
        if (accept && (full || up_Last)) begin
          ld      = 1'b1;
          ld_data = cat[2*BUS_WIDTH-1 -: BUS_WIDTH];
          ld_last = up_Last && !has_residual;
        end
      end
      FLUSH: begin
        if (free) begin
          ld      = 1'b1;
          ld_data = acc;
          ld_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Accumulator, fill level, sub-vector position, vector count and error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc  <= '0;
      fill <= '0;
      sub  <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else if (state == FLUSH) begin
      if (free) begin
        acc  <= '0;
        fill <= '0;
      end
    end else if (accept) begin
      if (full && (!up_Last || has_residual)) begin
        acc  <= cat[BUS_WIDTH-1:0];
        fill <= new_fill - FW'(BUS_WIDTH);
      end else if (up_Last) begin
        acc  <= '0;
        fill <= '0;
      end else begin
        acc  <= cat[2*BUS_WIDTH-1 -: BUS_WIDTH];
        fill <= new_fill;
      end
      sub <= (is_final || up_Last) ? '0 : sub + CW'(1);
      if (is_final)            cnt <= cnt + VEC_ID_WIDTH'(1);
      if (up_Last && !is_final) err <= 1'b1;
    end
  end

  vec_pack_outreg #(
    .WIDTH(BUS_WIDTH)
  ) u_outreg (
    .clk     (clk),
    .rstn    (rstn),
    .load    (ld),
    .data    (ld_data),
    .last    (ld_last),
    .ready   (dn_Ready),
    .valid   (dn_Valid),
    .vector  (dn_Vector),
    .is_last (dn_Last),
    .free    (free)
  );

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack: narrow hand-checked configurations plus the
// default configuration against a bit-stream model.
module tb_vec_pack;

  typedef logic [127:0] w_t;
  typedef w_t           wq_t[$];
  typedef bit           bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic verify(input string tag, input wq_t got_w, input bq_t got_l,
                        input wq_t exp_w, input bq_t exp_l);
    check({tag, "_count"}, 128'(got_w.size()), 128'(exp_w.size()));
    foreach (exp_w[i]) begin
      if (i < got_w.size()) begin
        check($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
        check($sformatf("%s_l%0d", tag, i), 128'(got_l[i]), 128'(exp_l[i]));
      end
    end
  endtask

  // ---------------- instance A: 8-bit bus, 20-bit vectors ----------------
  logic [7:0] a_vec, a_dvec, a_cnt;
  logic       a_valid, a_last, a_ready, a_dvalid, a_dlast, a_dready, a_err;
  wq_t        qa_w;
  bq_t        qa_l;

  vec_pack #(.BUS_WIDTH(8), .VECTOR_WIDTH(20), .VEC_ID_WIDTH(8)) u_a (
    .clk(clk), .rstn(rstn), .up_Vector(a_vec), .up_Valid(a_valid), .up_Last(a_last),
    .up_Ready(a_ready), .dn_Vector(a_dvec), .dn_Valid(a_dvalid), .dn_Last(a_dlast),
    .dn_Ready(a_dready), .dn_VecCnt(a_cnt), .dn_Err(a_err));

  always @(negedge clk) if (a_dvalid && a_dready) begin
    qa_w.push_back(128'(a_dvec));
    qa_l.push_back(a_dlast);
  end

  task automatic send_a(input logic [7:0] w, input bit last);
    bit ok = 0;
    @(posedge clk); #1;
    a_vec = w; a_last = last; a_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1; break; end
    end
    if (!ok) check("a_accept_timeout", 0, 1);
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  // ---------------- instance B: 8-bit bus, 22-bit vectors ----------------
  logic [7:0] b_vec, b_dvec, b_cnt;
  logic       b_valid, b_last, b_ready, b_dvalid, b_dlast, b_dready, b_err;
  wq_t        qb_w;
  bq_t        qb_l;

  vec_pack #(.BUS_WIDTH(8), .VECTOR_WIDTH(22), .VEC_ID_WIDTH(8)) u_b (
    .clk(clk), .rstn(rstn), .up_Vector(b_vec), .up_Valid(b_valid), .up_Last(b_last),
    .up_Ready(b_ready), .dn_Vector(b_dvec), .dn_Valid(b_dvalid), .dn_Last(b_dlast),
    .dn_Ready(b_dready), .dn_VecCnt(b_cnt), .dn_Err(b_err));

  always @(negedge clk) if (b_dvalid && b_dready) begin
    qb_w.push_back(128'(b_dvec));
    qb_l.push_back(b_dlast);
  end

  task automatic send_b(input logic [7:0] w, input bit last);
    bit ok = 0;
    @(posedge clk); #1;
    b_vec = w; b_last = last; b_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_ready) begin ok = 1; break; end
    end
    if (!ok) check("b_accept_timeout", 0, 1);
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  // ---------------- instance C: default parameters ----------------
  logic [127:0] c_vec, c_dvec;
  logic [7:0]   c_cnt;
  logic         c_valid, c_last, c_ready, c_dvalid, c_dlast, c_dready, c_err;
  wq_t          qc_w;
  bq_t          qc_l;
  bit           c_rand = 0;
  bit           c_hold = 0;
  logic [127:0] c_prev_vec;
  logic         c_prev_last;

  vec_pack u_c (
    .clk(clk), .rstn(rstn), .up_Vector(c_vec), .up_Valid(c_valid), .up_Last(c_last),
    .up_Ready(c_ready), .dn_Vector(c_dvec), .dn_Valid(c_dvalid), .dn_Last(c_dlast),
    .dn_Ready(c_dready), .dn_VecCnt(c_cnt), .dn_Err(c_err));

  always @(negedge clk) begin
    if (c_hold) begin
      check("c_stall_valid", 128'(c_dvalid), 1);
      check("c_stall_vec", c_dvec, c_prev_vec);
      check("c_stall_last", 128'(c_dlast), 128'(c_prev_last));
    end
    if (c_dvalid && c_dready) begin
      qc_w.push_back(c_dvec);
      qc_l.push_back(c_dlast);
    end
    c_hold      = c_dvalid && !c_dready;
    c_prev_vec  = c_dvec;
    c_prev_last = c_dlast;
  end

  always @(posedge clk) begin
    #1;
    if (c_rand) c_dready = 1'($urandom_range(0, 1));
  end

  logic [919:0]   vecs [16];
  logic [14719:0] stream;
  wq_t            exp_c_w;
  bq_t            exp_c_l;

  task automatic run_c(output int stalls);
    bit           ok;
    logic [127:0] w;
    stalls = 0;
    @(posedge clk); #1;
    for (int v = 0; v < 16; v++) begin
      for (int j = 0; j < 8; j++) begin
        if (j < 7) w = vecs[v][919 - 128*j -: 128];
        else       w = {vecs[v][23:0], 104'b0};
        c_vec = w; c_last = (v == 15 && j == 7); c_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (c_ready) begin ok = 1; break; end
          stalls++;
        end
        if (!ok) check("c_accept_timeout", 0, 1);
        @(posedge clk); #1;
      end
    end
    c_valid = 1'b0; c_last = 1'b0;
  endtask

  task automatic wait_c_words(input int n);
    bit ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (qc_w.size() >= n) begin ok = 1; break; end
    end
    if (!ok) check("c_drain_timeout", 0, 1);
    repeat (4) @(posedge clk);
  endtask

  wq_t ew;
  bq_t el;
  int  stalls;

  initial begin
    rstn = 1'b0;
    a_vec = '0; a_valid = 0; a_last = 0; a_dready = 1;
    b_vec = '0; b_valid = 0; b_last = 0; b_dready = 1;
    c_vec = '0; c_valid = 0; c_last = 0; c_dready = 1;
    repeat (2) @(posedge clk); #1;

    // Reset state
    check("rst_dn_valid", 128'(a_dvalid), 0);
    check("rst_dn_last", 128'(a_dlast), 0);
    check("rst_dn_vector", 128'(a_dvec), 0);
    check("rst_vec_cnt", 128'(a_cnt), 0);
    check("rst_err", 128'(a_err), 0);
    check("rst_up_ready", 128'(a_ready), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("run_up_ready", 128'(a_ready), 1);

    // One 20-bit vector 0xABCDE terminating a batch
    send_a(8'hAB, 0); send_a(8'hCD, 0); send_a(8'hE0, 1);
    repeat (3) @(posedge clk);
    ew = '{128'hAB, 128'hCD, 128'hE0}; el = '{0, 0, 1};
    verify("a_single", qa_w, qa_l, ew, el);
    check("a_cnt1", 128'(a_cnt), 1);
    qa_w.delete(); qa_l.delete();

    // Two vectors straddling word boundaries; residual zero at the end
    send_a(8'h12, 0); send_a(8'h34, 0); send_a(8'h50, 0);
    send_a(8'h67, 0); send_a(8'h89, 0); send_a(8'hA0, 1);
    repeat (3) @(posedge clk);
    ew = '{128'h12, 128'h34, 128'h56, 128'h78, 128'h9A}; el = '{0, 0, 0, 0, 1};
    verify("a_straddle", qa_w, qa_l, ew, el);
    check("a_cnt3", 128'(a_cnt), 3);
    check("a_err_clear", 128'(a_err), 0);
    qa_w.delete(); qa_l.delete();

    // Early up_Last on sub-vector 1, then a clean vector
    send_a(8'h12, 0); send_a(8'h34, 0); send_a(8'h50, 0);
    send_a(8'h67, 0); send_a(8'h89, 1);
    repeat (3) @(posedge clk);
    check("a_err_set", 128'(a_err), 1);
    send_a(8'hAB, 0); send_a(8'hCD, 0); send_a(8'hE0, 1);
    repeat (3) @(posedge clk);
    ew = '{128'h12, 128'h34, 128'h56, 128'h78, 128'h90, 128'hAB, 128'hCD, 128'hE0};
    el = '{0, 0, 0, 0, 1, 0, 0, 1};
    verify("a_err", qa_w, qa_l, ew, el);
    check("a_err_sticky", 128'(a_err), 1);
    check("a_cnt5", 128'(a_cnt), 5);
    qa_w.delete(); qa_l.delete();

    // Reset mid-vector with 4 bits held in the accumulator
    send_a(8'h12, 0); send_a(8'h34, 0); send_a(8'h50, 0); send_a(8'h67, 0);
    repeat (3) @(posedge clk);
    qa_w.delete(); qa_l.delete();
    #1 rstn = 1'b0;
    @(negedge clk);
    check("a_rst_up_ready", 128'(a_ready), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    check("a_rst_valid", 128'(a_dvalid), 0);
    check("a_rst_cnt", 128'(a_cnt), 0);
    check("a_rst_err", 128'(a_err), 0);
    send_a(8'hAB, 0); send_a(8'hCD, 0); send_a(8'hE0, 1);
    repeat (3) @(posedge clk);
    ew = '{128'hAB, 128'hCD, 128'hE0}; el = '{0, 0, 1};
    verify("a_after_rst", qa_w, qa_l, ew, el);
    check("a_after_rst_cnt", 128'(a_cnt), 1);

    // 22-bit vectors: 44 bits become 6 words with a flushed tail
    send_b(8'hA5, 0); send_b(8'h5A, 0); send_b(8'hCC, 0);
    send_b(8'h0F, 0); send_b(8'hF0, 0); send_b(8'hA8, 1);
    @(negedge clk);
    check("b_flush_up_ready", 128'(b_ready), 0);
    repeat (3) @(posedge clk);
    ew = '{128'hA5, 128'h5A, 128'hCC, 128'h3F, 128'hC2, 128'hA0}; el = '{0, 0, 0, 0, 0, 1};
    verify("b_flush", qb_w, qb_l, ew, el);
    check("b_cnt", 128'(b_cnt), 2);
    check("b_ready_back", 128'(b_ready), 1);

    // Default configuration: 16 random vectors against a flat bit-stream model
    for (int v = 0; v < 16; v++) begin
      logic [927:0] tmp;
      for (int k = 0; k < 29; k++) tmp[k*32 +: 32] = $urandom;
      vecs[v] = tmp[919:0];
      stream[14719 - 920*v -: 920] = vecs[v];
    end
    for (int k = 0; k < 115; k++) begin
      exp_c_w.push_back(stream[14719 - 128*k -: 128]);
      exp_c_l.push_back(k == 114);
    end

    run_c(stalls);
    wait_c_words(115);
    check("c_no_input_stall", 128'(stalls), 0);
    verify("c_run", qc_w, qc_l, exp_c_w, exp_c_l);
    check("c_cnt16", 128'(c_cnt), 16);
    qc_w.delete(); qc_l.delete();

    // Same traffic with downstream back-pressure toggling at random
    c_rand = 1;
    run_c(stalls);
    wait_c_words(115);
    c_rand = 0;
    @(posedge clk); #2;
    c_dready = 1'b1;
    verify("c_stall", qc_w, qc_l, exp_c_w, exp_c_l);
    check("c_cnt32", 128'(c_cnt), 32);
    check("c_err", 128'(c_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
